// File: rtl/divider_seq_if.sv
// Request/result bundle for the sequential divider.
// signed_i exists only when DIVIDER_SEQ_SIGNED_EN is defined.
interface divider_seq_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
`ifdef DIVIDER_SEQ_SIGNED_EN
    logic             signed_i;
`endif
    logic             busy_o;
    logic             finish_o;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;
    logic             div_by_zero_o;

    modport master (
        output start_i,
        output dividend_i,
        output divisor_i,
`ifdef DIVIDER_SEQ_SIGNED_EN
        output signed_i,
`endif
        input  busy_o,
        input  finish_o,
        input  quotient_o,
        input  remainder_o,
        input  div_by_zero_o
    );

    modport slave (
        input  start_i,
        input  dividend_i,
        input  divisor_i,
`ifdef DIVIDER_SEQ_SIGNED_EN
        input  signed_i,
`endif
        output busy_o,
        output finish_o,
        output quotient_o,
        output remainder_o,
        output div_by_zero_o
    );
endinterface

// File: rtl/divider_seq.sv
// Multi-cycle restoring divider, WIDTH bits, quotient/remainder/div-by-zero.
// Optional signed mode: define DIVIDER_SEQ_SIGNED_EN.
module divider_seq #(
    parameter int WIDTH = 8
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    divider_seq_if.slave bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;
    logic             zero_q;
    logic             neg_q_q;
    logic             neg_r_q;

    logic             sgn;
    logic             accept;
    logic             div_zero;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

`ifdef DIVIDER_SEQ_SIGNED_EN
    assign sgn = bus.signed_i;
`else
    assign sgn = 1'b0;
`endif

    assign accept   = (state_q == IDLE) && bus.start_i;
    assign div_zero = (bus.divisor_i == '0);
    assign a_neg    = sgn && bus.dividend_i[WIDTH-1];
    assign b_neg    = sgn && bus.divisor_i[WIDTH-1];

    // WIDTH+1-bit trial keeps the shifted-out MSB for large divisors
    assign trial  = {rem_q, dvd_q[WIDTH-1]};
    assign diff   = trial - {1'b0, dvs_q};
    assign ge     = (trial >= {1'b0, dvs_q});
    assign rem_nx = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_nx = {quo_q[WIDTH-2:0], ge};
    assign q_fix  = neg_q_q ? (~quo_nx + 1'b1) : quo_nx;
    assign r_fix  = neg_r_q ? (~rem_nx + 1'b1) : rem_nx;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (zero_q || (cnt_q == '0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
        end else if (accept) begin
            // a zero divisor keeps the raw dividend for the remainder
            if (a_neg && !div_zero) begin
                dvd_q <= ~bus.dividend_i + 1'b1;
            end else begin
                dvd_q <= bus.dividend_i;
            end
            dvs_q       <= b_neg ? (~bus.divisor_i + 1'b1)
                                 : bus.divisor_i;
            cnt_q       <= div_zero ? '0 : CW'(WIDTH - 1);
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            zero_q      <= div_zero;
            neg_q_q     <= a_neg ^ b_neg;
            neg_r_q     <= a_neg;
        end else if (state_q == CALC) begin
            if (zero_q) begin
                quotient_q  <= '1;
                remainder_q <= dvd_q;
                dbz_q       <= 1'b1;
            end else begin
                dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    quotient_q  <= q_fix;
                    remainder_q <= r_fix;
                end
            end
        end
    end

    assign bus.busy_o        = (state_q != IDLE);
    assign bus.finish_o      = (state_q == DONE);
    assign bus.quotient_o    = quotient_q;
    assign bus.remainder_o   = remainder_q;
    assign bus.div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Directed bench for divider_seq at WIDTH=8.
// Signed vectors run only when DIVIDER_SEQ_SIGNED_EN is defined.
module tb_divider_seq;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    divider_seq_if #(.WIDTH(8)) bus ();

    divider_seq #(.WIDTH(8)) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_finish(output int n, output bit gap);
        n   = 0;
        gap = 1'b0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!bus.busy_o) gap = 1'b1;
        end while (!bus.finish_o && n < 50);
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic sg);
        bus.dividend_i = a;
        bus.divisor_i  = b;
`ifdef DIVIDER_SEQ_SIGNED_EN
        bus.signed_i   = sg;
`else
        if (sg) $display("note: signed request ignored");
`endif
        bus.start_i    = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic sg,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic ez, input int lat);
        int n;
        bit gap;
        drive(a, b, sg);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        chk({tag, "_busy_start"}, 32'(bus.busy_o), 32'd1);
        chk({tag, "_q_clear"}, 32'(bus.quotient_o), 32'd0);
        wait_finish(n, gap);
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_busy_gap"}, 32'(gap), 32'd0);
        chk({tag, "_q"}, 32'(bus.quotient_o), 32'(eq));
        chk({tag, "_r"}, 32'(bus.remainder_o), 32'(er));
        chk({tag, "_dz"}, 32'(bus.div_by_zero_o), 32'(ez));
        @(posedge clk);
        #1;
        chk({tag, "_busy_end"}, 32'(bus.busy_o), 32'd0);
        chk({tag, "_fin_end"}, 32'(bus.finish_o), 32'd0);
        chk({tag, "_q_held"}, 32'(bus.quotient_o), 32'(eq));
    endtask

    initial begin
        int  n;
        bit  gap;
        bit  seen;
        vectors     = 0;
        miscompares = 0;
        rst_n          = 1'b0;
        bus.start_i    = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
`ifdef DIVIDER_SEQ_SIGNED_EN
        bus.signed_i   = 1'b0;
`endif
        #2;
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_fin", 32'(bus.finish_o), 32'd0);
        chk("rst_q", 32'(bus.quotient_o), 32'd0);
        chk("rst_r", 32'(bus.remainder_o), 32'd0);
        chk("rst_dz", 32'(bus.div_by_zero_o), 32'd0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("d200_7", 8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, 8);
        run_op("d5_0", 8'd5, 8'd0, 1'b0, 8'd255, 8'd5, 1'b1, 1);
        run_op("d9_3", 8'd9, 8'd3, 1'b0, 8'd3, 8'd0, 1'b0, 8);
        run_op("d3_10", 8'd3, 8'd10, 1'b0, 8'd0, 8'd3, 1'b0, 8);
        run_op("d255_255", 8'd255, 8'd255, 1'b0, 8'd1, 8'd0, 1'b0, 8);
        run_op("d255_129", 8'd255, 8'd129, 1'b0, 8'd1, 8'd126, 1'b0, 8);

        // second request during CALC must be dropped
        drive(8'd100, 8'd9, 1'b0);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drive(8'd50, 8'd5, 1'b0);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        wait_finish(n, gap);
        chk("ign_latency", 32'(n + 3), 32'd8);
        chk("ign_busy_gap", 32'(gap), 32'd0);
        chk("ign_q", 32'(bus.quotient_o), 32'd11);
        chk("ign_r", 32'(bus.remainder_o), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("ign_idle", 32'(bus.busy_o), 32'd0);

        // start held high: back-to-back every WIDTH+2 cycles
        drive(8'd9, 8'd3, 1'b0);
        wait_finish(n, gap);
        chk("b2b_first_q", 32'(bus.quotient_o), 32'd3);
        wait_finish(n, gap);
        chk("b2b_period", 32'(n), 32'd10);
        bus.start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_idle", 32'(bus.busy_o), 32'd0);

        // asynchronous reset in the middle of CALC
        drive(8'd200, 8'd7, 1'b0);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
        chk("mid_rst_fin", 32'(bus.finish_o), 32'd0);
        chk("mid_rst_q", 32'(bus.quotient_o), 32'd0);
        chk("mid_rst_r", 32'(bus.remainder_o), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.finish_o || bus.busy_o) seen = 1'b1;
        end
        chk("mid_rst_quiet", 32'(seen), 32'd0);
        run_op("d12_4", 8'd12, 8'd4, 1'b0, 8'd3, 8'd0, 1'b0, 8);

`ifdef DIVIDER_SEQ_SIGNED_EN
        run_op("s_m7_2", 8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 8);
        run_op("s_min_m1", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 8);
        run_op("s_m5_0", 8'hFB, 8'h00, 1'b1, 8'hFF, 8'hFB, 1'b1, 1);
        run_op("s_u200_7", 8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, 8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end, expected $finish");
        $fatal(1, "timeout");
    end

endmodule
